// File: rtl/serial_adder_unit.sv
// Bit-serial adder/subtractor: one full-adder slice plus carry flop, LSB first.
// Operands are captured on START; S/C/V update together with a one-cycle DONE pulse.
//
// state | meaning
// IDLE  | waiting for START
// RUN   | shifting one bit per clock through the adder slice (BUSY=1)
// FIN   | result registered, DONE=1; START here reloads with no idle gap
module serial_adder_unit #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             V
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cf_q, cf_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic             sum_bit;
    logic             carry_out;
    logic             load;
    logic [WIDTH-1:0] sum_vec;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_d     = res_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        cf_d      = cf_q;
        c_d       = c_q;
        v_d       = v_q;
        load      = 1'b0;
        sum_bit   = op_a_q[0] ^ op_b_q[0] ^ cf_q;
        carry_out = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & cf_q) | (op_b_q[0] & cf_q);
        sum_vec   = '0;
        sum_vec[WIDTH-1] = sum_bit;

        case (state_q)
            IDLE: begin
                load = START;
            end
            RUN: begin
                res_d  = (res_q >> 1) | sum_vec;
                cf_d   = carry_out;
                op_a_d = op_a_q >> 1;
                op_b_d = op_b_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                    s_d     = res_d;
                    c_d     = carry_out;
                    // cf_q on the last bit is the carry into the MSB
                    v_d     = cf_q ^ carry_out;
                end
            end
            FIN: begin
                load    = START;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            state_d = RUN;
            op_a_d  = A;
            op_b_d  = MODE ? ~B : B;
            cf_d    = MODE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cf_q    <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cf_q    <= cf_d;
            c_q     <= c_d;
            v_q     <= v_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign S    = s_q;
    assign C    = c_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit: an 8-bit instance for the main scenarios
// and a 1-bit instance for the degenerate registered full adder.
module tb_serial_adder_unit;

    logic       clk;
    logic       rst;
    logic       start, mode;
    logic [7:0] a, b;
    logic       busy, done;
    logic [7:0] s;
    logic       c, v;

    logic       start1, mode1;
    logic [0:0] a1, b1;
    logic       busy1, done1;
    logic [0:0] s1;
    logic       c1, v1;

    int errors = 0;
    int checks = 0;

    serial_adder_unit #(.WIDTH(8), .CW(6)) dut (
        .CLK(clk), .RST(rst), .START(start), .MODE(mode), .A(a), .B(b),
        .BUSY(busy), .DONE(done), .S(s), .C(c), .V(v)
    );

    serial_adder_unit #(.WIDTH(1), .CW(2)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .MODE(mode1), .A(a1), .B(b1),
        .BUSY(busy1), .DONE(done1), .S(s1), .C(c1), .V(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one START cycle; returns at the falling edge after the capture edge.
    task automatic start_op(input logic m, input logic [7:0] aa, input logic [7:0] bb);
        @(negedge clk);
        start = 1'b1; mode = m; a = aa; b = bb;
        @(negedge clk);
        start = 1'b0; mode = ~m; a = ~aa; b = ~bb;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a = 8'h00; b = 8'h00;
        start1 = 1'b0; mode1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, s, c, v} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b s=%h c=%b v=%b exp all 0", busy, done, s, c, v);
        end
        checks++;
        if ({busy1, done1, s1, c1, v1} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs_w1 got busy=%b done=%b s=%b c=%b v=%b exp all 0", busy1, done1, s1, c1, v1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        start_op(1'b0, 8'h5A, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle %0d got busy=%b done=%b exp busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_timing got done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        checks++;
        if ({s, c, v} !== {8'h96, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL basic_result got s=%h c=%b v=%b exp s=96 c=0 v=1", s, c, v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse got done=%b exp 0", done);
        end
    endtask

    task automatic test_carry_sub;
        int n;
        start_op(1'b0, 8'hFF, 8'h01);
        wait_done(20, n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL carry_latency got %0d cycles exp 8", n);
        end
        checks++;
        if ({s, c, v} !== {8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_result got s=%h c=%b v=%b exp s=00 c=1 v=0", s, c, v);
        end
        start_op(1'b1, 8'h05, 8'h07);
        wait_done(20, n);
        checks++;
        if (done !== 1'b1 || {s, c, v} !== {8'hFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow_result got done=%b s=%h c=%b v=%b exp done=1 s=fe c=0 v=0", done, s, c, v);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'h80; b = 8'h01;
        wait_done(20, n);
        checks++;
        if (done !== 1'b1 || {s, c, v} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first got done=%b s=%h c=%b v=%b exp done=1 s=7f c=1 v=1", done, s, c, v);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        wait_done(20, n);
        checks++;
        if (n + 1 != 9) begin
            errors++;
            $display("FAIL b2b_period got %0d cycles exp 9", n + 1);
        end
        checks++;
        if ({s, c, v} !== {8'h7F, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second got s=%h c=%b v=%b exp s=7f c=1 v=1", s, c, v);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got busy=%b done=%b exp busy=0 done=0", busy, done);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        int done_seen;
        start_op(1'b0, 8'h5A, 8'h3C);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, s, c, v} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b s=%h c=%b v=%b exp all 0", busy, done, s, c, v);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_no_done got %0d active cycles exp 0", done_seen);
        end
        start_op(1'b0, 8'h5A, 8'h3C);
        wait_done(20, n);
        checks++;
        if (done !== 1'b1 || {s, c, v} !== {8'h96, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_recover got done=%b s=%h c=%b v=%b exp done=1 s=96 c=0 v=1", done, s, c, v);
        end
    endtask

    task automatic test_ignore_start;
        int n;
        int s_bad;
        s_bad = 0;
        start_op(1'b0, 8'h11, 8'h22);
        if (s !== 8'h96) s_bad++;
        @(negedge clk);
        if (s !== 8'h96) s_bad++;
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            if (s !== 8'h96) s_bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_bad != 0) begin
            errors++;
            $display("FAIL ignore_s_stable got %0d changed samples exp 0", s_bad);
        end
        checks++;
        if (done !== 1'b1 || {s, c, v} !== {8'h33, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ignore_result got done=%b s=%h c=%b v=%b exp done=1 s=33 c=0 v=0", done, s, c, v);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_retrigger got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_width1;
        logic [3:0] exp_s;
        logic [3:0] exp_c;
        exp_s = 4'b0110;
        exp_c = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start1 = 1'b1; mode1 = 1'b0;
            a1 = (i >= 2) ? 1'b1 : 1'b0;
            b1 = (i % 2 == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            start1 = 1'b0; a1 = ~a1; b1 = ~b1;
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL w1_busy combo %0d got busy=%b done=%b exp busy=1 done=0", i, busy1, done1);
            end
            @(negedge clk);
            checks++;
            if (done1 !== 1'b1 || s1[0] !== exp_s[i] || c1 !== exp_c[i] || v1 !== exp_c[i]) begin
                errors++;
                $display("FAIL w1_result combo %0d got done=%b s=%b c=%b v=%b exp done=1 s=%b c=%b v=%b",
                         i, done1, s1, c1, v1, exp_s[i], exp_c[i], exp_c[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_ignore_start();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
